apb_wr_rd_scheduler: RTL and testbench
======================================

Name: apb_wr_rd_scheduler

Overview:
- Sequencer/arbiter on the APB (master) clock side of the AXI4Lite-to-APB4 bridge.
- Watches the write-address, write-data and read-address CDC FIFO flags, plus the read-data FIFO full flag.
- Decides whether the next APB transfer is a write or a read, weighted by the CSR write/read ratio.
- Hands one command at a time to the APB transfer FSM and pops the source FIFOs when that command is accepted.

Parameters:
- RATIO_W, 3, width of the wr_rd_ratio CSR field.
- CNT_W, 16, width of the statistics counters (used only with the optional feature).

Ports:
- PCLK_i  in  1  APB master clock; all logic on the rising edge.
- PRESET_i  in  1  asynchronous, active-high reset.
- wr_rd_ratio  in  RATIO_W  max consecutive write grants minus 1 while a read is pending.
- wa_empty  in  1  write-address FIFO empty.
- wd_empty  in  1  write-data FIFO empty.
- ra_empty  in  1  read-address FIFO empty.
- rd_full  in  1  read-data FIFO full.
- wa_pop  out  1  write-address FIFO pop pulse.
- wd_pop  out  1  write-data FIFO pop pulse.
- ra_pop  out  1  read-address FIFO pop pulse.
- cmd_valid  out  1  command offered to the APB transfer FSM.
- cmd_write  out  1  1 = write command, 0 = read command; stable while cmd_valid is high.
- cmd_ready  in  1  APB transfer FSM accepts the command.
- cmd_done  in  1  one-cycle pulse when the APB transfer completes (PREADY seen).
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (PRESET_i high, asynchronous): state IDLE, wr_streak 0, cmd_valid/cmd_write/pops/busy all 0.
- Eligibility:
  - wr_elig = !wa_empty & !wd_empty.
  - rd_elig = !ra_empty & !rd_full.
- FSM states: IDLE, ISSUE, WAIT_DONE.
- IDLE:
  - Neither eligible: stay in IDLE.
  - Only wr_elig: grant write.
  - Only rd_elig: grant read.
  - Both eligible: grant write if wr_streak <= wr_rd_ratio, otherwise grant read.
  - Any grant: register cmd_write and move to ISSUE. cmd_valid rises the next cycle (1-cycle latency from eligibility).
- ISSUE:
  - cmd_valid = 1, cmd_write held; no retraction and no re-arbitration.
  - On cmd_valid & cmd_ready in the same cycle: pulse the pops for exactly that cycle (wa_pop+wd_pop for a write, ra_pop for a read), then go to WAIT_DONE.
  - FIFO rdata is show-ahead, so the APB FSM samples it in the accept cycle.
- WAIT_DONE:
  - cmd_valid = 0.
  - cmd_done moves to IDLE next cycle; earliest following cmd_valid is 2 cycles after cmd_done.
  - cmd_done in any other state is ignored.
- wr_streak (RATIO_W+1 bits):
  - +1 on each write grant, saturating at 2^RATIO_W.
  - Cleared on each read grant.
  - Net effect: ratio N gives N+1 writes per read under contention; ratio 0 gives strict alternation.
- Boundary cases:
  - rd_full rising during ISSUE/WAIT_DONE does not affect the command in flight; it only blocks the next read grant.
  - wr_rd_ratio changing mid-stream takes effect at the next arbitration and does not clear wr_streak.
  - Only one outstanding command; no pipelining.
  - Reset mid-transfer returns to IDLE immediately and suppresses pops.

Optional Feature:
- Macro APB_WR_RD_SCHED_STATS_EN.
- When defined:
  - Adds outputs wr_grant_cnt [CNT_W-1:0] and rd_grant_cnt [CNT_W-1:0].
  - Each increments on an accepted command of its type, wraps modulo 2^CNT_W, and resets to 0.
  - Adds input stats_clr, a synchronous clear that takes priority over increment in the same cycle.
- When undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package bridge_pkg holds:
  - FSM state enum (SCH_IDLE, SCH_ISSUE, SCH_WAIT_DONE);
  - RATIO_W default;
  - command-type constants CMD_RD=0, CMD_WR=1.
- One natural sub-module: sched_weight_arb, the combinational eligibility/priority decision plus the wr_streak register. It outputs grant_vld and grant_wr.

Test Plan:
- After reset, all FIFOs empty for 10 cycles -> cmd_valid, pops and busy stay 0.
- Write only (wa_empty=wd_empty=0, ra_empty=1), cmd_ready tied 1, cmd_done 2 cycles after accept -> cmd_write=1; wa_pop and wd_pop each 1 cycle in the accept cycle, ra_pop never; repeat period 5 cycles.
- Both eligible continuously, wr_rd_ratio=2 -> grant sequence W,W,W,R,W,W,W,R; with wr_rd_ratio=0 -> W,R,W,R.
- Read pending with rd_full=1 while writes are pending, ratio=0 -> only writes granted; rd_full drops -> next grant is a read.
- cmd_ready held 0 for 4 cycles in ISSUE -> cmd_valid/cmd_write stable throughout, no pops until cmd_ready=1; cmd_done pulsed in ISSUE is ignored.
- PRESET_i asserted in WAIT_DONE -> outputs 0 asynchronously; after release the next grant is write-first with wr_streak=0; with APB_WR_RD_SCHED_STATS_EN, 3 writes + 1 read -> wr_grant_cnt=3, rd_grant_cnt=1, and stats_clr zeroes both.

Source files
------------

// File: rtl/bridge_pkg.sv
// Shared types and constants for the AXI4Lite-to-APB4 bridge.
package bridge_pkg;

  // Default width of the write/read ratio CSR field
  localparam int unsigned SCH_RATIO_W = 3;

  // Command type encoding on cmd_write
  localparam logic CMD_RD = 1'b0;
  localparam logic CMD_WR = 1'b1;

  // APB-side scheduler FSM states
  typedef enum logic [1:0] {
    SCH_IDLE      = 2'd0,
    SCH_ISSUE     = 2'd1,
    SCH_WAIT_DONE = 2'd2
  } sch_state_e;

endpackage

// File: rtl/sched_weight_arb.sv
// Weighted write/read arbiter: eligibility, priority decision and the
// consecutive-write streak counter that enforces the write/read ratio.
module sched_weight_arb
  import bridge_pkg::*;
#(
  parameter int unsigned RATIO_W = SCH_RATIO_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               arb_en,
  input  logic [RATIO_W-1:0] wr_rd_ratio,
  input  logic               wa_empty,
  input  logic               wd_empty,
  input  logic               ra_empty,
  input  logic               rd_full,
  output logic               grant_vld,
  output logic               grant_wr
);

  localparam logic [RATIO_W:0] STREAK_MAX = {1'b1, {RATIO_W{1'b0}}};

  logic             wr_elig;
  logic             rd_elig;
  logic [RATIO_W:0] wr_streak;

  // Grant decision: writes win a contended slot until the streak exceeds the ratio
  always_comb begin
    wr_elig   = !wa_empty && !wd_empty;
    rd_elig   = !ra_empty && !rd_full;
    grant_vld = arb_en && (wr_elig || rd_elig);
    grant_wr  = wr_elig && (!rd_elig || (wr_streak <= {1'b0, wr_rd_ratio}));
  end

  // Streak counter: saturating count of write grants since the last read grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_streak <= '0;
    end else if (grant_vld) begin
      if (grant_wr) begin
        if (wr_streak != STREAK_MAX) begin
          wr_streak <= wr_streak + 1'b1;
        end
      end else begin
        wr_streak <= '0;
      end
    end
  end

endmodule

// File: rtl/apb_wr_rd_scheduler.sv
// APB-side write/read scheduler: picks the next transfer type, offers it to
// the APB transfer FSM and pops the CDC FIFOs on acceptance.
// Optional grant statistics are enabled by defining APB_WR_RD_SCHED_STATS_EN.
module apb_wr_rd_scheduler
  import bridge_pkg::*;
#(
  parameter int unsigned RATIO_W = SCH_RATIO_W,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               PCLK_i,
  input  logic               PRESET_i,
  input  logic [RATIO_W-1:0] wr_rd_ratio,
  input  logic               wa_empty,
  input  logic               wd_empty,
  input  logic               ra_empty,
  input  logic               rd_full,
  output logic               wa_pop,
  output logic               wd_pop,
  output logic               ra_pop,
  output logic               cmd_valid,
  output logic               cmd_write,
  input  logic               cmd_ready,
  input  logic               cmd_done,
  output logic               busy
`ifdef APB_WR_RD_SCHED_STATS_EN
  ,
  input  logic               stats_clr,
  output logic [CNT_W-1:0]   wr_grant_cnt,
  output logic [CNT_W-1:0]   rd_grant_cnt
`endif
);

  sch_state_e state_q;
  sch_state_e state_d;
  logic       cmd_write_q;
  logic       grant_vld;
  logic       grant_wr;
  logic       accept;

  sched_weight_arb #(
    .RATIO_W (RATIO_W)
  ) u_arb (
    .clk         (PCLK_i),
    .rst         (PRESET_i),
    .arb_en      (state_q == SCH_IDLE),
    .wr_rd_ratio (wr_rd_ratio),
    .wa_empty    (wa_empty),
    .wd_empty    (wd_empty),
    .ra_empty    (ra_empty),
    .rd_full     (rd_full),
    .grant_vld   (grant_vld),
    .grant_wr    (grant_wr)
  );

  // State and latched command type
  always_ff @(posedge PCLK_i or posedge PRESET_i) begin
    if (PRESET_i) begin
      state_q     <= SCH_IDLE;
      cmd_write_q <= CMD_RD;
    end else begin
      state_q <= state_d;
      if (state_q == SCH_IDLE && grant_vld) begin
        cmd_write_q <= grant_wr;
      end
    end
  end

  // Next state and outputs; pops are decoded from the registered state so
  // an asynchronous reset suppresses them immediately
  always_comb begin
    state_d   = state_q;
    cmd_valid = 1'b0;
    accept    = 1'b0;
    busy      = (state_q != SCH_IDLE);
    cmd_write = cmd_write_q;
    unique case (state_q)
      SCH_IDLE: begin
        if (grant_vld) begin
          state_d = SCH_ISSUE;
        end
      end
      SCH_ISSUE: begin
        cmd_valid = 1'b1;
        if (cmd_ready) begin
          accept  = 1'b1;
          state_d = SCH_WAIT_DONE;
        end
      end
      SCH_WAIT_DONE: begin
        if (cmd_done) begin
          state_d = SCH_IDLE;
        end
      end
      default: state_d = SCH_IDLE;
    endcase
    wa_pop = accept && (cmd_write_q == CMD_WR);
    wd_pop = accept && (cmd_write_q == CMD_WR);
    ra_pop = accept && (cmd_write_q == CMD_RD);
  end

`ifdef APB_WR_RD_SCHED_STATS_EN
  // Accepted-command counters; clear wins over a same-cycle increment
  always_ff @(posedge PCLK_i or posedge PRESET_i) begin
    if (PRESET_i) begin
      wr_grant_cnt <= '0;
      rd_grant_cnt <= '0;
    end else if (stats_clr) begin
      wr_grant_cnt <= '0;
      rd_grant_cnt <= '0;
    end else if (accept) begin
      if (cmd_write_q == CMD_WR) begin
        wr_grant_cnt <= wr_grant_cnt + 1'b1;
      end else begin
        rd_grant_cnt <= rd_grant_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_apb_wr_rd_scheduler.sv
// Directed self-checking bench for apb_wr_rd_scheduler.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_apb_wr_rd_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] wr_rd_ratio;
  logic       wa_empty, wd_empty, ra_empty, rd_full;
  logic       wa_pop, wd_pop, ra_pop;
  logic       cmd_valid, cmd_write, cmd_ready, cmd_done, busy;
`ifdef APB_WR_RD_SCHED_STATS_EN
  logic        stats_clr;
  logic [15:0] wr_grant_cnt, rd_grant_cnt;
`endif

  int checks = 0;
  int errors = 0;

  apb_wr_rd_scheduler #(
    .RATIO_W (3),
    .CNT_W   (16)
  ) dut (
    .PCLK_i      (clk),
    .PRESET_i    (rst),
    .wr_rd_ratio (wr_rd_ratio),
    .wa_empty    (wa_empty),
    .wd_empty    (wd_empty),
    .ra_empty    (ra_empty),
    .rd_full     (rd_full),
    .wa_pop      (wa_pop),
    .wd_pop      (wd_pop),
    .ra_pop      (ra_pop),
    .cmd_valid   (cmd_valid),
    .cmd_write   (cmd_write),
    .cmd_ready   (cmd_ready),
    .cmd_done    (cmd_done),
    .busy        (busy)
`ifdef APB_WR_RD_SCHED_STATS_EN
    ,
    .stats_clr    (stats_clr),
    .wr_grant_cnt (wr_grant_cnt),
    .rd_grant_cnt (rd_grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transfer with cmd_ready high: valid one cycle after the previous
  // IDLE cycle, two quiet WAIT_DONE cycles, cmd_done, then one IDLE cycle
  // (5-cycle period under continuous eligibility).
  task automatic xfer(input string tag, input logic exp_wr);
    int n = 0;
    while (cmd_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_latency"}, n, 1);
    chk({tag, "_write"}, cmd_write, exp_wr);
    chk({tag, "_pops"}, {wa_pop, wd_pop, ra_pop}, {exp_wr, exp_wr, ~exp_wr});
    step();
    chk({tag, "_wait"}, {cmd_valid, wa_pop, wd_pop, ra_pop, busy}, 5'b00001);
    step();
    step();
    cmd_done = 1'b1;
    step();
    cmd_done = 1'b0;
    chk({tag, "_idle"}, {busy, cmd_valid}, 2'b00);
  endtask

  initial begin
    rst = 1'b1;
    wr_rd_ratio = 3'd0;
    wa_empty = 1'b1; wd_empty = 1'b1; ra_empty = 1'b1; rd_full = 1'b0;
    cmd_ready = 1'b0; cmd_done = 1'b0;
`ifdef APB_WR_RD_SCHED_STATS_EN
    stats_clr = 1'b0;
`endif
    step();
    step();
    chk("reset_out", {cmd_valid, cmd_write, wa_pop, wd_pop, ra_pop, busy}, 6'b0);
    rst = 1'b0;

    // Idle with all FIFOs empty
    for (int i = 0; i < 10; i++) begin
      step();
      chk("empty_idle", {cmd_valid, wa_pop, wd_pop, ra_pop, busy}, 5'b0);
    end

    // Write-only traffic: streak ends at 3
    wa_empty = 1'b0; wd_empty = 1'b0; cmd_ready = 1'b1;
    xfer("wonly0", 1'b1);
    xfer("wonly1", 1'b1);
    xfer("wonly2", 1'b1);

    // Contention, ratio 2, entering with streak 3 -> read first
    ra_empty = 1'b0; wr_rd_ratio = 3'd2;
    xfer("r2_0", 1'b0);
    xfer("r2_1", 1'b1);
    xfer("r2_2", 1'b1);
    xfer("r2_3", 1'b1);
    xfer("r2_4", 1'b0);
    xfer("r2_5", 1'b1);
    xfer("r2_6", 1'b1);
    xfer("r2_7", 1'b1);

    // Ratio 0 (streak 3 on entry) -> strict alternation
    wr_rd_ratio = 3'd0;
    xfer("r0_0", 1'b0);
    xfer("r0_1", 1'b1);
    xfer("r0_2", 1'b0);
    xfer("r0_3", 1'b1);

    // Read blocked by rd_full: only writes, then the read once it drops
    rd_full = 1'b1;
    xfer("full_0", 1'b1);
    xfer("full_1", 1'b1);
    rd_full = 1'b0;
    xfer("full_rd", 1'b0);

    // Back-pressure: cmd_ready low for 4 cycles, stray cmd_done ignored
    ra_empty = 1'b1; cmd_ready = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      chk("hold_cmd", {cmd_valid, cmd_write, busy}, 3'b111);
      chk("hold_pops", {wa_pop, wd_pop, ra_pop}, 3'b000);
      cmd_done = (i == 1);
      step();
    end
    cmd_done = 1'b0;
    cmd_ready = 1'b1;
    #1;
    chk("hold_accept", {cmd_valid, wa_pop, wd_pop, ra_pop}, 4'b1110);
    step();
    chk("hold_wait", {cmd_valid, busy}, 2'b01);
    cmd_done = 1'b1;
    step();
    cmd_done = 1'b0;
    chk("hold_idle", busy, 1'b0);

    // Asynchronous reset while in WAIT_DONE
    ra_empty = 1'b0; wr_rd_ratio = 3'd2;
    step();
    chk("pre_rst_valid", cmd_valid, 1'b1);
    step();
    chk("pre_rst_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst", {cmd_valid, cmd_write, wa_pop, wd_pop, ra_pop, busy}, 6'b0);
    step();
    rst = 1'b0;

    // Streak cleared by reset: write-first W,W,W,R at ratio 2
    xfer("post_rst0", 1'b1);
    xfer("post_rst1", 1'b1);
    xfer("post_rst2", 1'b1);
    xfer("post_rst3", 1'b0);

`ifdef APB_WR_RD_SCHED_STATS_EN
    chk("wr_cnt", wr_grant_cnt, 16'd3);
    chk("rd_cnt", rd_grant_cnt, 16'd1);
    wa_empty = 1'b1; wd_empty = 1'b1; ra_empty = 1'b1;
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    chk("cnt_clr", {wr_grant_cnt, rd_grant_cnt}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule
